// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and reset/exception PCs for the elastic pipeline stage.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int          PC_W         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle: upstream (in_*) and downstream (out_*) sides of one stage.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 96
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_skid_sat_cnt.sv
// Saturating event counter used by the stage statistics (only built with PIPE_STAGE_STATS_EN).
module pipe_sat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with 2-entry skid buffer and registered in_ready; flush loads a PC bubble.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined.
//
// state | meaning
// EMPTY | no payload held, out_data is the bubble
// ONE   | main slot valid, skid slot free
// TWO   | main and skid slots valid, upstream stalled
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int          DATA_W   = 96,
  parameter int          PC_LSB   = 0,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_PC   = EXC_PC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               Req,
  pipe_stage_skid_if.slave   bus
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        bubble_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  function automatic logic [DATA_W-1:0] make_bubble(input logic [PC_W-1:0] pc);
    logic [DATA_W-1:0] b;
    b = '0;
    b[PC_LSB +: PC_W] = pc;
    return b;
  endfunction

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [PC_W-1:0]   bubble_pc_q, bubble_pc_d;
  logic              acc, pop;

  assign acc = bus.in_valid & in_ready_q & clk_en;
  assign pop = out_valid_q & bus.out_ready & clk_en;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    bubble_pc_d = bubble_pc_q;

    if (Req) begin
      state_d     = EMPTY;
      main_d      = make_bubble(EXC_PC);
      skid_d      = '0;
      bubble_pc_d = EXC_PC;
    end else if (clk_en) begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = bus.in_data;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_d = bus.in_data;
          end else if (acc) begin
            state_d = TWO;
            skid_d  = bus.in_data;
          end else if (pop) begin
            state_d = EMPTY;
            main_d  = make_bubble(bubble_pc_q);
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = make_bubble(bubble_pc_q);
          skid_d  = '0;
        end
      endcase
    end

    // Port flags are re-derived from the next state so they can be flops.
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= make_bubble(RESET_PC);
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_pc_q <= RESET_PC;
    end else begin
      bubble_pc_q <= bubble_pc_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;

`ifdef PIPE_STAGE_STATS_EN
  logic stall_inc, bubble_inc;

  assign stall_inc  = out_valid_q & ~bus.out_ready & clk_en;
  assign bubble_inc = ~out_valid_q & clk_en;

  pipe_sat_cnt #(.WIDTH(32)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  pipe_sat_cnt #(.WIDTH(32)) u_bubble_cnt (
    .clk (clk),
    .clr (reset),
    .inc (bubble_inc),
    .cnt (bubble_cnt)
  );

  pipe_sat_cnt #(.WIDTH(32)) u_flush_cnt (
    .clk (clk),
    .clr (reset),
    .inc (Req),
    .cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: occupancy model predicts in_ready/out_valid, queue predicts data.
module tb_pipe_stage_skid;

  localparam int          DW  = 96;
  localparam int          PCL = 8;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;
  logic Req;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [31:0]   exp_pc;

  pipe_stage_skid_if #(.DATA_W(DW)) bus ();

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
`endif

  pipe_stage_skid #(
    .DATA_W   (DW),
    .PC_LSB   (PCL),
    .RESET_PC (RST_PC),
    .EXC_PC   (EXC_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .Req        (Req),
    .bus        (bus)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] bubble(input logic [31:0] pc);
    logic [DW-1:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) b[PCL + i] = pc[i];
    return b;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // One clock of stimulus plus the scoreboard/occupancy monitor.
  task automatic step(input logic iv, input logic [DW-1:0] din, input logic ordy,
                      input logic en, input logic rq);
    logic acc, pop;
    bus.in_valid  = iv;
    bus.in_data   = din;
    bus.out_ready = ordy;
    clk_en        = en;
    Req           = rq;
    acc = iv & bus.in_ready & en & ~rq;
    pop = bus.out_valid & ordy & en & ~rq;
    if (pop) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_pop_empty out_data=%h but scoreboard empty", bus.out_data);
      end else if (bus.out_data !== q[0]) begin
        errors++;
        $display("FAIL sb_data got %h exp %h", bus.out_data, q[0]);
      end
    end
    @(posedge clk);
    if (rq) begin
      q.delete();
      exp_pc = EXC_PC;
    end else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(din);
    end
    #1;
    checks++;
    if (bus.out_valid !== (q.size() != 0)) begin
      errors++;
      $display("FAIL occ_out_valid got %b exp %b", bus.out_valid, (q.size() != 0));
    end
    checks++;
    if (bus.in_ready !== (q.size() < 2)) begin
      errors++;
      $display("FAIL occ_in_ready got %b exp %b", bus.in_ready, (q.size() < 2));
    end
    if (q.size() == 0) begin
      checks++;
      if (bus.out_data !== bubble(exp_pc)) begin
        errors++;
        $display("FAIL bubble_data got %h exp %h", bus.out_data, bubble(exp_pc));
      end
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b1;
    bus.in_data   = rnd_data();
    bus.out_ready = 1'b0;
    clk_en        = 1'b0;
    Req           = 1'b0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    exp_pc = RST_PC;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
    end
    checks++;
    if (bus.out_data !== bubble(RST_PC)) begin
      errors++;
      $display("FAIL reset_out_data got %h exp %h", bus.out_data, bubble(RST_PC));
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] d[3];
    for (int i = 0; i < 3; i++) d[i] = rnd_data();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, d[i], 1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== d[i]) begin
        errors++;
        $display("FAIL stream_latency item %0d got v=%b %h exp v=1 %h", i, bus.out_valid, bus.out_data, d[i]);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_in_ready item %0d got %b exp 1", i, bus.in_ready);
      end
    end
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, c;
    a = rnd_data(); b = rnd_data(); c = rnd_data();
    step(1'b1, a, 1'b0, 1'b1, 1'b0);
    step(1'b1, b, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full_in_ready got %b exp 0", bus.in_ready);
    end
    step(1'b1, c, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.out_data !== b || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_pop got %h rdy=%b exp %h rdy=1", bus.out_data, bus.in_ready, b);
    end
    step(1'b1, c, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.out_data !== c) begin
      errors++;
      $display("FAIL bp_c_order got %h exp %h", bus.out_data, c);
    end
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    step(1'b1, rnd_data(), 1'b0, 1'b1, 1'b0);
    step(1'b1, rnd_data(), 1'b0, 1'b1, 1'b0);
    step(1'b1, rnd_data(), 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== bubble(EXC_PC)) begin
      errors++;
      $display("FAIL flush_state got v=%b rdy=%b %h exp v=0 rdy=1 %h",
               bus.out_valid, bus.in_ready, bus.out_data, bubble(EXC_PC));
    end
    repeat (3) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_clk_en();
    logic [DW-1:0] a, b;
    a = rnd_data(); b = rnd_data();
    step(1'b1, a, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, b, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.out_data !== a || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL freeze cycle %0d got v=%b rdy=%b %h exp v=1 rdy=1 %h",
                 i, bus.out_valid, bus.in_ready, bus.out_data, a);
      end
    end
    step(1'b1, b, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.out_data !== b) begin
      errors++;
      $display("FAIL freeze_resume got %h exp %h", bus.out_data, b);
    end
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      step(($urandom_range(0, 3) != 0), rnd_data(), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 7) != 0), 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain got %0d left exp 0", q.size());
    end
  endtask

`ifdef PIPE_STAGE_STATS_EN
  task automatic test_stats();
    clk_en = 1'b1;
    Req    = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    exp_pc = RST_PC;
    step(1'b1, rnd_data(), 1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (stall_cnt !== 32'd4) begin
      errors++;
      $display("FAIL stats_stall got %0d exp 4", stall_cnt);
    end
    checks++;
    if (!(bubble_cnt >= 32'd2)) begin
      errors++;
      $display("FAIL stats_bubble got %0d exp >=2", bubble_cnt);
    end
    checks++;
    if (flush_cnt !== 32'd1) begin
      errors++;
      $display("FAIL stats_flush got %0d exp 1", flush_cnt);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    exp_pc = RST_PC;
    checks++;
    if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL stats_clear got %0d/%0d/%0d exp 0/0/0", stall_cnt, bubble_cnt, flush_cnt);
    end
  endtask
`endif

  initial begin
    reset         = 1'b1;
    clk_en        = 1'b0;
    Req           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    exp_pc        = RST_PC;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_clk_en();
    test_back_to_back();
`ifdef PIPE_STAGE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
